counter_arbiter: RTL and testbench

COUNTER_ARBITER -- requirements
Module: counter_arbiter

---
 rtl/counter_arbiter.sv | 132 +++++++++++++
 tb/tb_counter_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_arbiter.sv
// Round-robin arbiter that grants a shared external counter to one of two
// requesters. The owner's counter is cleared, counts up to the owner's
// latched length, and then gets a one-cycle done pulse.
module counter_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  input  logic [WIDTH-1:0] counter_out,
  output logic             cnt_reset,
  output logic             cnt_enable,
  output logic [1:0]       grant,
  output logic [1:0]       done,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_owner;
  logic             w_owner_nxt;
  logic             r_last;
  logic             w_last_nxt;
  logic [WIDTH-1:0] r_len_q;
  logic [WIDTH-1:0] w_len_nxt;
  logic [1:0]       r_grant;
  logic [1:0]       w_grant_nxt;
  logic [1:0]       r_done;
  logic [1:0]       w_done_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_cnt_reset;
  logic             w_cnt_reset_nxt;

  logic             w_owner_req;
  logic             w_at_len;
  logic             w_pick;

  // Owner still requesting, and counter has hit the latched terminal count
  assign w_owner_req = req[r_owner];
  assign w_at_len    = (counter_out == r_len_q);

  // On a tie the requester not served last wins; a lone request always wins
  assign w_pick = (req == 2'b11) ? ~r_last : req[1];

  // Count enable is combinational so the counter stops exactly at len_q
  assign cnt_enable = (r_state == S_COUNT) && !w_at_len;

  assign grant     = r_grant;
  assign done      = r_done;
  assign busy      = r_busy;
  assign cnt_reset = r_cnt_reset;

  // Next-state, owner, pointer and registered-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_len_nxt   = r_len_q;

    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_owner_nxt = w_pick;
          w_len_nxt   = w_pick ? len1 : len0;
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (!w_owner_req) begin
          w_last_nxt  = r_owner;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_COUNT;
        end
      end
      S_COUNT: begin
        if (!w_owner_req) begin
          w_last_nxt  = r_owner;
          w_state_nxt = S_IDLE;
        end else if (w_at_len) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_last_nxt  = r_owner;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_cnt_reset_nxt = (w_state_nxt == S_CLEAR);
    w_grant_nxt     = (w_state_nxt != S_IDLE) ? {w_owner_nxt, ~w_owner_nxt} : 2'b00;
    w_done_nxt      = (w_state_nxt == S_DONE) ? {w_owner_nxt, ~w_owner_nxt} : 2'b00;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_len_q     <= '0;
      r_grant     <= 2'b00;
      r_done      <= 2'b00;
      r_busy      <= 1'b0;
      r_cnt_reset <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_last      <= w_last_nxt;
      r_len_q     <= w_len_nxt;
      r_grant     <= w_grant_nxt;
      r_done      <= w_done_nxt;
      r_busy      <= w_busy_nxt;
      r_cnt_reset <= w_cnt_reset_nxt;
    end
  end

endmodule

// File: tb/tb_counter_arbiter.sv
// Self-checking bench for counter_arbiter with a model of the shared counter
// and a scoreboard of expected done pulses (owner, cycle, counter value).
module tb_counter_arbiter;

  localparam int unsigned WIDTH = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic [1:0]       req;
  logic [WIDTH-1:0] len0;
  logic [WIDTH-1:0] len1;
  logic [WIDTH-1:0] counter_out;
  logic             cnt_reset;
  logic             cnt_enable;
  logic [1:0]       grant;
  logic [1:0]       done;
  logic             busy;

  typedef struct {
    logic [1:0]       done;
    int               cycle;
    logic [WIDTH-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic mon_en = 1'b0;

  counter_arbiter #(.WIDTH(WIDTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .len0        (len0),
    .len1        (len1),
    .counter_out (counter_out),
    .cnt_reset   (cnt_reset),
    .cnt_enable  (cnt_enable),
    .grant       (grant),
    .done        (done),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Shared counter model driven by the arbiter
  always @(posedge clock) begin
    if (reset || cnt_reset) counter_out <= '0;
    else if (cnt_enable)    counter_out <= counter_out + WIDTH'(1);
  end

  // Scoreboard: every done pulse must match the oldest expected entry
  always @(negedge clock) begin
    exp_t e;
    if (mon_en && (done !== 2'b00)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done: got done=%b at cycle %0d, expected no pulse", done, cyc);
      end else begin
        e = sb.pop_front();
        if (done !== e.done || cyc != e.cycle || counter_out !== e.cnt) begin
          errors++;
          $display("FAIL sb_done: got done=%b cycle=%0d cnt=%0d, expected done=%b cycle=%0d cnt=%0d",
                   done, cyc, counter_out, e.done, e.cycle, e.cnt);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] d, input int c, input logic [WIDTH-1:0] n);
    exp_t e;
    e.done  = d;
    e.cycle = c;
    e.cnt   = n;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 2'b00;
    tick();
    tick();
    checks++;
    if ({grant, done, cnt_reset, cnt_enable, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got grant=%b done=%b clr=%b en=%b busy=%b, expected all 0",
               grant, done, cnt_reset, cnt_enable, busy);
    end
    reset  = 1'b0;
    mon_en = 1'b1;
    tick();
    checks++;
    if ({grant, busy} !== 3'b0) begin
      errors++;
      $display("FAIL reset_idle: got grant=%b busy=%b, expected 0", grant, busy);
    end
  endtask

  task automatic test_single();
    int t;
    len0 = WIDTH'(5);
    req  = 2'b01;
    t    = cyc;
    push_exp(2'b01, t + 8, WIDTH'(5));
    tick();
    checks++;
    if ({grant, cnt_reset, cnt_enable, busy} !== 5'b01101) begin
      errors++;
      $display("FAIL single_clear: got grant=%b clr=%b en=%b busy=%b, expected 01 1 0 1",
               grant, cnt_reset, cnt_enable, busy);
    end
    len0 = WIDTH'(2);
    tick();
    for (int k = 0; k <= 5; k++) begin
      checks++;
      if (counter_out !== WIDTH'(k) || cnt_enable !== (k != 5) || cnt_reset !== 1'b0 || grant !== 2'b01) begin
        errors++;
        $display("FAIL single_count: k=%0d got cnt=%0d en=%b clr=%b grant=%b, expected cnt=%0d en=%b clr=0 grant=01",
                 k, counter_out, cnt_enable, cnt_reset, grant, k, (k != 5));
      end
      if (k == 1) req = 2'b11;
      if (k == 2) req = 2'b01;
      tick();
    end
    checks++;
    if (done !== 2'b01 || grant !== 2'b01 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_done: got done=%b grant=%b busy=%b, expected 01 01 1", done, grant, busy);
    end
    req = 2'b00;
    tick();
    checks++;
    if ({grant, done, busy} !== 5'b0 || counter_out !== WIDTH'(5)) begin
      errors++;
      $display("FAIL single_after: got grant=%b done=%b busy=%b cnt=%0d, expected 0 0 0 5",
               grant, done, busy, counter_out);
    end
    tick();
    checks++;
    if (grant !== 2'b00) begin
      errors++;
      $display("FAIL single_dropped_req: got grant=%b, expected 00", grant);
    end
  endtask

  task automatic test_tie();
    int t;
    logic [1:0] exp_g;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    len0  = WIDTH'(2);
    len1  = WIDTH'(2);
    req   = 2'b11;
    t     = cyc;
    push_exp(2'b01, t + 5,  WIDTH'(2));
    push_exp(2'b10, t + 11, WIDTH'(2));
    push_exp(2'b01, t + 17, WIDTH'(2));
    for (int k = 1; k <= 17; k++) begin
      tick();
      exp_g = (k == 6 || k == 12) ? 2'b00 : ((k < 6 || k > 12) ? 2'b01 : 2'b10);
      checks++;
      if (grant !== exp_g) begin
        errors++;
        $display("FAIL tie_grant: k=%0d got grant=%b, expected %b", k, grant, exp_g);
      end
    end
    req = 2'b00;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL tie_idle: got busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_full_scale();
    int t;
    len0 = WIDTH'(15);
    req  = 2'b01;
    t    = cyc;
    push_exp(2'b01, t + 18, WIDTH'(15));
    tick();
    tick();
    for (int k = 0; k <= 15; k++) begin
      checks++;
      if (counter_out !== WIDTH'(k) || cnt_enable !== (k != 15)) begin
        errors++;
        $display("FAIL full_count: k=%0d got cnt=%0d en=%b, expected cnt=%0d en=%b",
                 k, counter_out, cnt_enable, k, (k != 15));
      end
      tick();
    end
    checks++;
    if (done !== 2'b01) begin
      errors++;
      $display("FAIL full_done: got done=%b, expected 01", done);
    end
    req = 2'b00;
    tick();
    checks++;
    if (counter_out !== WIDTH'(15) || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_nowrap: got cnt=%0d busy=%b, expected 15 0", counter_out, busy);
    end
  endtask

  task automatic test_zero_len();
    int t;
    len1 = WIDTH'(0);
    req  = 2'b10;
    t    = cyc;
    push_exp(2'b10, t + 3, WIDTH'(0));
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (cnt_enable !== 1'b0 || grant !== 2'b10) begin
        errors++;
        $display("FAIL zero_en: k=%0d got en=%b grant=%b, expected 0 10", k, cnt_enable, grant);
      end
      if (k == 2) begin
        checks++;
        if (counter_out !== WIDTH'(0)) begin
          errors++;
          $display("FAIL zero_cnt: got cnt=%0d, expected 0", counter_out);
        end
      end
    end
    checks++;
    if (done !== 2'b10) begin
      errors++;
      $display("FAIL zero_done: got done=%b, expected 10", done);
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_abort();
    int t;
    len0 = WIDTH'(9);
    req  = 2'b01;
    tick();
    tick();
    repeat (3) tick();
    checks++;
    if (counter_out !== WIDTH'(3) || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: got cnt=%0d busy=%b, expected 3 1", counter_out, busy);
    end
    req = 2'b00;
    tick();
    checks++;
    if ({grant, done, busy, cnt_enable, cnt_reset} !== 7'b0) begin
      errors++;
      $display("FAIL abort_idle: got grant=%b done=%b busy=%b en=%b clr=%b, expected all 0",
               grant, done, busy, cnt_enable, cnt_reset);
    end
    len1 = WIDTH'(1);
    req  = 2'b11;
    t    = cyc;
    push_exp(2'b10, t + 4, WIDTH'(1));
    tick();
    checks++;
    if (grant !== 2'b10) begin
      errors++;
      $display("FAIL abort_next_grant: got grant=%b, expected 10", grant);
    end
    repeat (3) tick();
    checks++;
    if (done !== 2'b10) begin
      errors++;
      $display("FAIL abort_next_done: got done=%b, expected 10", done);
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid_count();
    int t;
    len0 = WIDTH'(9);
    req  = 2'b01;
    tick();
    tick();
    repeat (4) tick();
    checks++;
    if (counter_out !== WIDTH'(4) || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: got cnt=%0d busy=%b, expected 4 1", counter_out, busy);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({grant, done, cnt_reset, cnt_enable, busy} !== 7'b0) begin
      errors++;
      $display("FAIL midrst_outputs: got grant=%b done=%b clr=%b en=%b busy=%b, expected all 0",
               grant, done, cnt_reset, cnt_enable, busy);
    end
    reset = 1'b0;
    len0  = WIDTH'(1);
    len1  = WIDTH'(3);
    req   = 2'b11;
    t     = cyc;
    push_exp(2'b01, t + 4, WIDTH'(1));
    tick();
    checks++;
    if (grant !== 2'b01) begin
      errors++;
      $display("FAIL midrst_grant: got grant=%b, expected 01", grant);
    end
    repeat (3) tick();
    checks++;
    if (done !== 2'b01) begin
      errors++;
      $display("FAIL midrst_done: got done=%b, expected 01", done);
    end
    req = 2'b00;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    req   = 2'b00;
    len0  = '0;
    len1  = '0;
    test_reset();
    test_single();
    test_tie();
    test_full_scale();
    test_zero_len();
    test_abort();
    test_reset_mid_count();
    repeat (3) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending entries, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
